// File: rtl/avr_dram_arbiter_if.sv
// ============================================================================
// Module      : avr_dram_arbiter_if
// Description : Bus bundle for the AVR data-RAM arbiter: core port A,
//               secondary port B and the single-port RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface avr_dram_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    // Port A (core data bus)
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ready;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    // Port B (secondary master)
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_lock;
    logic              b_ready;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    // RAM side
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Arbiter view
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ready, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata, b_lock,
        output b_ready, b_rvalid, b_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    // Requesters / RAM view
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ready, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata, b_lock,
        input  b_ready, b_rvalid, b_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

`default_nettype wire

// File: rtl/avr_dram_arbiter.sv
// ============================================================================
// Module      : avr_dram_arbiter
// Description : Arbitrates the single-port AVR data RAM between the core (A,
//               fixed priority) and a secondary master (B) with a starvation
//               guard and a bounded burst lock. RAM read latency of 1 cycle
//               is passed through unchanged.
//               Optional macro AVR_DRAM_ARB_STATS_EN adds b_wait_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avr_dram_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 8
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    avr_dram_arbiter_if.slave bus
`ifdef AVR_DRAM_ARB_STATS_EN
    ,
    output logic [15:0]       b_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        A_PRI   = 2'd0,
        B_FORCE = 2'd1,
        B_LOCK  = 2'd2
    } state_t;

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
    localparam logic [7:0] c_burst_max    = 8'(BURST_MAX);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_starve, w_starve_nxt;
    logic [7:0]        r_burst, w_burst_nxt;
    logic              r_rd_a, r_rd_b;
    logic              w_pick_a, w_pick_b;
    logic              w_grant_a, w_grant_b;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // Grant selection, starvation counting and state transitions
    always_comb begin
        w_pick_a     = 1'b0;
        w_pick_b     = 1'b0;
        w_state_nxt  = r_state;
        w_burst_nxt  = r_burst;
        w_starve_nxt = r_starve;

        case (r_state)
            B_FORCE: w_pick_b = bus.b_req;
            B_LOCK:  w_pick_b = bus.b_req & bus.b_lock;
            default: begin
                w_pick_a = bus.a_req;
                w_pick_b = ~bus.a_req & bus.b_req;
            end
        endcase

        if (w_pick_b || !bus.b_req)
            w_starve_nxt = 4'd0;
        else if (r_starve < c_starve_limit)
            w_starve_nxt = r_starve + 4'd1;

        case (r_state)
            A_PRI: begin
                // The forced slot follows on the very cycle after the limit is hit
                if (w_pick_b && bus.b_lock) begin
                    if (c_burst_max > 8'd1) begin
                        w_state_nxt = B_LOCK;
                        w_burst_nxt = 8'd1;
                    end
                end else if (w_starve_nxt == c_starve_limit) begin
                    w_state_nxt = B_FORCE;
                end
            end
            B_FORCE: begin
                if (w_pick_b && bus.b_lock && c_burst_max > 8'd1) begin
                    w_state_nxt = B_LOCK;
                    w_burst_nxt = 8'd1;
                end else begin
                    w_state_nxt = A_PRI;
                end
            end
            B_LOCK: begin
                if (w_pick_b && (r_burst + 8'd1 != c_burst_max)) begin
                    w_burst_nxt = r_burst + 8'd1;
                end else begin
                    w_state_nxt = A_PRI;
                    w_burst_nxt = 8'd0;
                end
            end
            default: begin
                w_state_nxt = A_PRI;
                w_burst_nxt = 8'd0;
            end
        endcase
    end

    // Grants are forced low while reset is asserted so the RAM sees no strobe
    assign w_grant_a = w_pick_a & reset_n;
    assign w_grant_b = w_pick_b & reset_n;

    assign w_addr  = w_grant_a ? bus.a_addr  : (w_grant_b ? bus.b_addr  : '0);
    assign w_wdata = w_grant_a ? bus.a_wdata : (w_grant_b ? bus.b_wdata : '0);

    assign bus.a_ready   = w_grant_a;
    assign bus.b_ready   = w_grant_b;
    assign bus.ram_en    = w_grant_a | w_grant_b;
    assign bus.ram_we    = (w_grant_a & bus.a_we) | (w_grant_b & bus.b_we);
    assign bus.ram_addr  = w_addr;
    assign bus.ram_wdata = w_wdata;

    assign bus.a_rvalid = r_rd_a;
    assign bus.b_rvalid = r_rd_b;
    assign bus.a_rdata  = r_rd_a ? bus.ram_rdata : '0;
    assign bus.b_rdata  = r_rd_b ? bus.ram_rdata : '0;

    // Arbiter state, counters and read-return tags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= A_PRI;
            r_starve <= 4'd0;
            r_burst  <= 8'd0;
            r_rd_a   <= 1'b0;
            r_rd_b   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            r_burst  <= w_burst_nxt;
            r_rd_a   <= w_grant_a & ~bus.a_we;
            r_rd_b   <= w_grant_b & ~bus.b_we;
        end
    end

`ifdef AVR_DRAM_ARB_STATS_EN
    logic [15:0] r_wait_cnt;

    // Saturating count of cycles where B was left waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_wait_cnt <= 16'd0;
        else if (bus.b_req && !w_grant_b && r_wait_cnt != 16'hFFFF)
            r_wait_cnt <= r_wait_cnt + 16'd1;
    end

    assign b_wait_cnt = r_wait_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_avr_dram_arbiter.sv
// ============================================================================
// Module      : tb_avr_dram_arbiter
// Description : Self-checking bench for avr_dram_arbiter: directed scenarios
//               followed by randomized traffic, compared every cycle against
//               a behavioural ownership model with a shadow RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avr_dram_arbiter;

    localparam int ADDR_W       = 11;
    localparam int DATA_W       = 8;
    localparam int STARVE_LIMIT = 4;
    localparam int BURST_MAX    = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear_mem = 1'b1;

    always #5 clk = ~clk;

    avr_dram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef AVR_DRAM_ARB_STATS_EN
    logic [15:0] b_wait_cnt;
`endif

    avr_dram_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT),
        .BURST_MAX    (BURST_MAX)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef AVR_DRAM_ARB_STATS_EN
        ,
        .b_wait_cnt (b_wait_cnt)
`endif
    );

    // Synchronous single-port RAM, 1-cycle read latency
    logic [7:0] mem [0:2047];
    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
        end else if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the RAM, how long B has waited, what is owed
    logic [7:0] shadow [0:2047];
    int  m_owner;   // 0 = core has priority, 1 = B owed one slot, 2 = B holds lock
    int  m_wait;    // consecutive cycles B has been refused
    int  m_left;    // locked transfers B may still take
    bit  m_pend_a, m_pend_b;
    logic [7:0] m_data_a, m_data_b;
    int  m_bwait;
    bit  m_last_gb;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_wait   = 0;
        m_left   = 0;
        m_pend_a = 1'b0;
        m_pend_b = 1'b0;
        m_data_a = 8'h00;
        m_data_b = 8'h00;
        m_bwait  = 0;
        m_last_gb = 1'b0;
    endtask

    task automatic start_burst();
        m_left  = BURST_MAX - 1;
        m_owner = (m_left == 0) ? 0 : 2;
    endtask

    // Predict this cycle, compare, then advance the model
    task automatic model_step();
        bit ga, gb, exp_we;
        logic [10:0] exp_addr;
        logic [7:0]  exp_wdata;
        ga = 1'b0;
        gb = 1'b0;
        case (m_owner)
            2:       gb = bus.b_req && bus.b_lock;
            1:       gb = bus.b_req;
            default: begin
                ga = bus.a_req;
                gb = !bus.a_req && bus.b_req;
            end
        endcase
        exp_we    = ga ? bus.a_we    : (gb ? bus.b_we    : 1'b0);
        exp_addr  = ga ? bus.a_addr  : (gb ? bus.b_addr  : 11'h000);
        exp_wdata = ga ? bus.a_wdata : (gb ? bus.b_wdata : 8'h00);

        check_eq("a_ready",   32'(bus.a_ready),   32'(ga));
        check_eq("b_ready",   32'(bus.b_ready),   32'(gb));
        check_eq("ram_en",    32'(bus.ram_en),    32'(ga | gb));
        check_eq("ram_we",    32'(bus.ram_we),    32'(exp_we));
        check_eq("ram_addr",  32'(bus.ram_addr),  32'(exp_addr));
        check_eq("ram_wdata", 32'(bus.ram_wdata), 32'(exp_wdata));
        check_eq("a_rvalid",  32'(bus.a_rvalid),  32'(m_pend_a));
        check_eq("b_rvalid",  32'(bus.b_rvalid),  32'(m_pend_b));
        check_eq("a_rdata",   32'(bus.a_rdata),   32'(m_pend_a ? m_data_a : 8'h00));
        check_eq("b_rdata",   32'(bus.b_rdata),   32'(m_pend_b ? m_data_b : 8'h00));
`ifdef AVR_DRAM_ARB_STATS_EN
        check_eq("b_wait_cnt", 32'(b_wait_cnt), 32'(m_bwait));
`endif

        m_pend_a = ga && !bus.a_we;
        m_pend_b = gb && !bus.b_we;
        if (m_pend_a) m_data_a = shadow[bus.a_addr];
        if (m_pend_b) m_data_b = shadow[bus.b_addr];
        if (ga && bus.a_we) shadow[bus.a_addr] = bus.a_wdata;
        if (gb && bus.b_we) shadow[bus.b_addr] = bus.b_wdata;

        if (bus.b_req && !gb && m_bwait < 65535) m_bwait++;

        if (gb)              m_wait = 0;
        else if (bus.b_req)  m_wait = (m_wait < STARVE_LIMIT) ? m_wait + 1 : m_wait;
        else                 m_wait = 0;

        case (m_owner)
            2: begin
                if (gb) begin
                    m_left--;
                    if (m_left == 0) m_owner = 0;
                end else begin
                    m_owner = 0;
                end
            end
            1: begin
                if (gb && bus.b_lock) start_burst();
                else                  m_owner = 0;
            end
            default: begin
                if (gb && bus.b_lock)          start_burst();
                else if (m_wait == STARVE_LIMIT) m_owner = 1;
            end
        endcase
        m_last_gb = gb;
    endtask

    // One clock cycle of stimulus; rst pulses reset_n low mid-cycle instead
    task automatic step(input bit ar, input bit aw, input logic [10:0] aa, input logic [7:0] ad,
                        input bit br, input bit bw, input logic [10:0] ba, input logic [7:0] bd,
                        input bit bl, input bit rst);
        @(posedge clk);
        #1;
        bus.a_req = ar && !rst; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
        bus.b_req = br && !rst; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
        bus.b_lock = bl;
        if (rst) begin
            #1 reset_n = 1'b0;
            @(negedge clk);
            check_eq("rst_ram_en",   32'(bus.ram_en),   32'd0);
            check_eq("rst_a_ready",  32'(bus.a_ready),  32'd0);
            check_eq("rst_b_ready",  32'(bus.b_ready),  32'd0);
            check_eq("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
            check_eq("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
            check_eq("rst_a_rdata",  32'(bus.a_rdata),  32'd0);
`ifdef AVR_DRAM_ARB_STATS_EN
            check_eq("rst_b_wait_cnt", 32'(b_wait_cnt), 32'd0);
`endif
            model_reset();
            #2 reset_n = 1'b1;
        end else begin
            @(negedge clk);
            model_step();
        end
    endtask

    function automatic logic [10:0] rand_addr();
        int x;
        x = $urandom_range(0, 31);
        return (x < 16) ? 11'(x) : 11'(32'h100 + x - 16);
    endfunction

    initial begin
        int bi;
        int pa, pb, pl, pw;
        for (int i = 0; i < 2048; i++) shadow[i] = 8'h00;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0; bus.b_lock = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 clear_mem = 1'b0;
        @(negedge clk);
        // Reset-state outputs
        check_eq("init_ram_en",  32'(bus.ram_en),  32'd0);
        check_eq("init_a_ready", 32'(bus.a_ready), 32'd0);
        reset_n = 1'b1;

        // B writes 0x5A to 0x012, A reads it back
        step(0, 0, 11'h000, 8'h00, 1, 1, 11'h012, 8'h5A, 0, 0);
        step(1, 0, 11'h012, 8'h00, 0, 0, 11'h000, 8'h00, 0, 0);
        step(0, 0, 11'h000, 8'h00, 0, 0, 11'h000, 8'h00, 0, 0);

        // Both requesting continuously: starvation guard window
        for (int i = 0; i < 20; i++)
            step(1, 0, 11'(i), 8'h00, 1, 0, 11'h012, 8'h00, 0, 0);
        step(0, 0, 11'h000, 8'h00, 0, 0, 11'h000, 8'h00, 0, 0);

        // Locked burst of 10 B writes at 0x100.., core pressing from the 2nd cycle
        bi = 0;
        for (int i = 0; i < 30 && bi < 10; i++) begin
            step(i > 0, 0, 11'h012, 8'h00, 1, 1, 11'(32'h100 + bi), 8'(8'hC0 + bi), 1, 0);
            if (m_last_gb) bi++;
        end
        for (int i = 0; i < 10; i++)
            step(0, 0, 11'h000, 8'h00, 1, 0, 11'(32'h100 + i), 8'h00, 0, 0);

        // Alternating A and B reads
        for (int i = 0; i < 12; i++)
            step(i % 2 == 0, 0, 11'(32'h100 + i), 8'h00, i % 2 == 1, 0, 11'(32'h109 - i), 8'h00, 0, 0);

        // Reset right after an accepted A read, then a simultaneous request
        step(1, 0, 11'h012, 8'h00, 0, 0, 11'h000, 8'h00, 0, 0);
        step(1, 0, 11'h012, 8'h00, 1, 0, 11'h013, 8'h00, 0, 1);
        step(1, 0, 11'h012, 8'h00, 1, 0, 11'h013, 8'h00, 0, 0);
        step(0, 0, 11'h000, 8'h00, 0, 0, 11'h000, 8'h00, 0, 0);

        // Randomized traffic in segments of varying pressure
        for (int s = 0; s < 40; s++) begin
            pa = $urandom_range(0, 100);
            pb = $urandom_range(0, 100);
            pl = $urandom_range(0, 100);
            pw = $urandom_range(0, 100);
            for (int c = 0; c < 40; c++) begin
                step($urandom_range(0, 99) < pa, $urandom_range(0, 99) < pw, rand_addr(), 8'($urandom),
                     $urandom_range(0, 99) < pb, $urandom_range(0, 99) < pw, rand_addr(), 8'($urandom),
                     $urandom_range(0, 99) < pl, $urandom_range(0, 299) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/avr_dram_arbiter.md
Name: avr_dram_arbiter

Overview:
- Arbitrates the single-port AVR data RAM between the core data bus (port A) and a secondary master (port B), e.g. a UART loader or DMA engine.
- Sits between avr_core and ram inside top; the RAM's synchronous read latency of 1 cycle is preserved.
- Fixed priority goes to the core.
- Port B is protected by a starvation guard and may hold a short burst lock.

Parameters:
ADDR_W, 11, RAM address width
DATA_W, 8, RAM data width
STARVE_LIMIT, 4, consecutive denied B cycles before B is forced a slot (legal range 1..15)
BURST_MAX, 8, maximum consecutive B transfers under lock (legal range 1..255)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
a_req  in  1  core requests access
a_we  in  1  core write (1) / read (0)
a_addr  in  ADDR_W  core address
a_wdata  in  DATA_W  core write data
a_ready  out  1  core request accepted this cycle
a_rvalid  out  1  core read data valid
a_rdata  out  DATA_W  core read data
b_req, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata  same as port A, for port B
b_lock  in  1  B requests to keep the grant for its following transfers
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_en with ram_we=0

Behaviour:
- Grant is combinational from the request inputs and the registered state.
  - a_ready = grant_a; b_ready = grant_b.
  - At most one grant per cycle.
  - A transfer is accepted when req & ready.
- RAM outputs mux from the granted port.
  - ram_en = grant_a | grant_b.
  - With no grant, ram_we = 0 and addr/wdata are don't-care (drive 0).
- Reads: registered flags rd_a/rd_b are set on an accepted read.
  - x_rvalid is high exactly 1 cycle after acceptance.
  - x_rdata = ram_rdata when its rvalid is high, else 0.
  - Writes produce no rvalid.
- State machine: A_PRI (reset state), B_FORCE, B_LOCK.
  - A_PRI: grant A if a_req, else B if b_req.
  - A_PRI -> B_FORCE when starve_cnt reaches STARVE_LIMIT.
  - A_PRI -> B_LOCK when B is accepted with b_lock=1.
  - B_FORCE: grant B if b_req, A denied. Leave after one accepted B transfer: to B_LOCK if b_lock=1, else to A_PRI. Return to A_PRI if b_req drops.
  - B_LOCK: grant B while b_req & b_lock, and A is denied. burst_cnt increments per accepted B transfer (count includes the entry transfer).
  - B_LOCK -> A_PRI when b_req=0, b_lock=0, or burst_cnt reaches BURST_MAX. burst_cnt clears on exit.
  - After a BURST_MAX exit, the first cycle in A_PRI grants A if a_req, even with starve_cnt at its limit.
- starve_cnt (4-bit):
  - Increments each cycle b_req & !b_ready, saturating at STARVE_LIMIT.
  - Clears when B is accepted or b_req=0.
- Simultaneous a_req and b_req in A_PRI with starve_cnt < STARVE_LIMIT: A wins.
- Back-to-back transfers: one per cycle, no bubble between accepts.
- Reset (asynchronous, mid-operation included): all outputs 0, state A_PRI, all counters 0. A pending rvalid is dropped.

Optional Feature:
- AVR_DRAM_ARB_STATS_EN defined:
  - Adds output b_wait_cnt [15:0].
  - Counts cycles with b_req & !b_ready, saturating at 16'hFFFF.
  - Cleared by reset only.
- Not defined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- A-only read @0x012 after a B write of 0x5A to 0x012 -> a_ready=1 same cycle; a_rvalid=1 next cycle with a_rdata=0x5A; b_rvalid stays 0.
- a_req and b_req held continuously, STARVE_LIMIT=4 -> A granted 4 cycles; B granted on cycle 5 with a_ready=0; A granted again on cycle 6.
- B burst: b_lock=1, b_req for 10 writes at 0x100..0x109 while a_req=1, BURST_MAX=8 -> B accepts 8 writes back-to-back; cycle 9 grants A; B resumes after.
- Alternating A read / B read every cycle -> each x_rvalid appears exactly 1 cycle after its accept; no data cross-routing.
- reset_n pulled low the cycle after an accepted A read -> a_rvalid stays 0; ram_en=0; state returns to A_PRI. First post-reset simultaneous request grants A.
- Stats build: b_req=1 with a_req=1 for 20 cycles, STARVE_LIMIT=4 -> b_wait_cnt=16 (4 denied per 5-cycle window).
